// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, result-broadcast, flush and issue signals of the ALU
// reservation station, bundled so the station and its environment connect
// through one port.
//
// Handshake rule for both in_* and issue_*: a transfer happens on a rising
// clock edge where valid and ready are both 1. The producer holds valid and
// its payload steady until that edge. Ready may depend on state only, never
// on the same-cycle valid.
interface alu_rs_if #(
    parameter int TAG_W = 4
);
    // Dispatch from decode
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;
    logic [TAG_W-1:0] in_qj;
    logic [TAG_W-1:0] in_qk;
    logic [TAG_W-1:0] in_dest;

    // Common data bus (result broadcast)
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    // Pipeline flush
    logic             flush;

    // Issue toward the ALU
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_op;
    logic [31:0]      issue_src1;
    logic [31:0]      issue_src2;
    logic [TAG_W-1:0] issue_dest;

    // Environment side: decode, CDB, flush source and the ALU
    modport master (
        output in_valid, in_op, in_vj, in_vk, in_qj, in_qk, in_dest,
        output cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
        input  in_ready, issue_valid, issue_op, issue_src1, issue_src2, issue_dest
    );

    // Reservation station side
    modport slave (
        input  in_valid, in_op, in_vj, in_vk, in_qj, in_qk, in_dest,
        input  cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
        output in_ready, issue_valid, issue_op, issue_src1, issue_src2, issue_dest
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station. Holds DEPTH instructions waiting for their
// operands, captures results from the common data bus, and issues the
// lowest-index ready entry into a registered output stage toward the ALU.
//
// Optional feature macro: ALU_RS_BYPASS_EN. When defined, a dispatch whose
// operands are both present goes straight into the output register if that
// register can load and no held entry is ready, saving one cycle and no
// entry. When undefined, every dispatch goes through an entry.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic     clk,
    input logic     rst_n,
    alu_rs_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
    } entry_t;

    // Station state
    logic [DEPTH-1:0] busy_q, busy_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];

    // Output register toward the ALU
    logic             issue_valid_q, issue_valid_d;
    logic [2:0]       issue_op_q, issue_op_d;
    logic [31:0]      issue_src1_q, issue_src1_d;
    logic [31:0]      issue_src2_q, issue_src2_d;
    logic [TAG_W-1:0] issue_dest_q, issue_dest_d;

    // Selection and control
    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic             free_found;
    logic             rdy_found;
    logic             cdb_hit;
    logic             loadable;
    logic             dispatch;
    logic             do_issue;
    logic             bypass;
    entry_t           in_ent;

    // An entry is ready once it is busy and both operand tags have cleared.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
        end
    end

    // Lowest-index free slot and lowest-index ready slot; scanning downward
    // lets the last hit (smallest index) win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming instruction with same-cycle CDB forwarding applied, so an
    // operand produced this very cycle is never missed.
    always_comb begin
        cdb_hit     = bus.cdb_valid && (bus.cdb_tag != '0);
        in_ent.op   = bus.in_op;
        in_ent.vj   = bus.in_vj;
        in_ent.vk   = bus.in_vk;
        in_ent.qj   = bus.in_qj;
        in_ent.qk   = bus.in_qk;
        in_ent.dest = bus.in_dest;
        if (cdb_hit && (bus.in_qj == bus.cdb_tag)) begin
            in_ent.vj = bus.cdb_value;
            in_ent.qj = '0;
        end
        if (cdb_hit && (bus.in_qk == bus.cdb_tag)) begin
            in_ent.vk = bus.cdb_value;
            in_ent.qk = '0;
        end
    end

    // Handshake decisions for this cycle. in_ready reflects slots free at
    // cycle start, so a slot freed by this cycle's issue is not handed out
    // until the next cycle.
    always_comb begin
        loadable = !issue_valid_q || bus.issue_ready;
        dispatch = bus.in_valid && free_found;
        do_issue = loadable && rdy_found;
`ifdef ALU_RS_BYPASS_EN
        bypass   = dispatch && loadable && !rdy_found &&
                   (in_ent.qj == '0) && (in_ent.qk == '0);
`else
        bypass   = 1'b0;
`endif
    end

    // Next state: wakeup, issue, dispatch, then flush overriding everything.
    always_comb begin
        busy_d        = busy_q;
        ent_d         = ent_q;
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_src1_d  = issue_src1_q;
        issue_src2_d  = issue_src2_q;
        issue_dest_d  = issue_dest_q;

        if (cdb_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && (ent_q[i].qj == bus.cdb_tag)) begin
                    ent_d[i].vj = bus.cdb_value;
                    ent_d[i].qj = '0;
                end
                if (busy_q[i] && (ent_q[i].qk == bus.cdb_tag)) begin
                    ent_d[i].vk = bus.cdb_value;
                    ent_d[i].qk = '0;
                end
            end
        end

        if (do_issue) begin
            busy_d[rdy_idx] = 1'b0;
            issue_valid_d   = 1'b1;
            issue_op_d      = ent_q[rdy_idx].op;
            issue_src1_d    = ent_q[rdy_idx].vj;
            issue_src2_d    = ent_q[rdy_idx].vk;
            issue_dest_d    = ent_q[rdy_idx].dest;
        end else if (bypass) begin
            issue_valid_d   = 1'b1;
            issue_op_d      = in_ent.op;
            issue_src1_d    = in_ent.vj;
            issue_src2_d    = in_ent.vk;
            issue_dest_d    = in_ent.dest;
        end else if (loadable) begin
            issue_valid_d   = 1'b0;
        end

        // The dispatch slot was free at cycle start and the issue slot was
        // busy, so the two can never be the same entry.
        if (dispatch && !bypass) begin
            busy_d[free_idx] = 1'b1;
            ent_d[free_idx]  = in_ent;
        end

        if (bus.flush) begin
            busy_d        = '0;
            issue_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_src1_q  <= '0;
            issue_src2_q  <= '0;
            issue_dest_q  <= '0;
        end else begin
            busy_q        <= busy_d;
            ent_q         <= ent_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_src1_q  <= issue_src1_d;
            issue_src2_q  <= issue_src2_d;
            issue_dest_q  <= issue_dest_d;
        end
    end

    assign bus.in_ready    = free_found;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_op    = issue_op_q;
    assign bus.issue_src1  = issue_src1_q;
    assign bus.issue_src2  = issue_src2_q;
    assign bus.issue_dest  = issue_dest_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic for alu_rs. A
// list-based reference model predicts every issued instruction; a separate
// monitor checks in_ready/issue_valid each cycle and pops the expected queue
// on every issue handshake.
module tb_alu_rs;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int OUT_W = 3 + 32 + 32 + TAG_W;
`ifdef ALU_RS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_BGE = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rs_if #(.TAG_W(TAG_W)) bus ();

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
    } instr_t;

    instr_t           m_slot [DEPTH];
    bit               m_busy [DEPTH];
    bit               m_valid;
    logic [OUT_W-1:0] exp_q[$];

    function automatic logic [OUT_W-1:0] pack_out(input instr_t x);
        return {x.op, x.vj, x.vk, x.dest};
    endfunction

    function automatic bit model_in_ready();
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        if (m_valid) void'(exp_q.pop_back());
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        m_valid = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs on the bus.
    // A loaded instruction is pushed as soon as it reaches the output
    // register; one that is flushed away unconsumed is pulled back off.
    task automatic model_step();
        int     rdy;
        int     fre;
        bit     hit;
        bit     loadable;
        bit     disp;
        bit     byp;
        instr_t nw;
        hit = bus.cdb_valid && (bus.cdb_tag != 0);
        if (bus.flush) begin
            if (m_valid && !bus.issue_ready) void'(exp_q.pop_back());
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            m_valid = 1'b0;
            return;
        end
        rdy = -1;
        fre = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy < 0 && m_busy[i] && m_slot[i].qj == 0 && m_slot[i].qk == 0) rdy = i;
            if (fre < 0 && !m_busy[i]) fre = i;
        end
        nw.op   = bus.in_op;
        nw.dest = bus.in_dest;
        nw.vj   = (hit && bus.in_qj == bus.cdb_tag) ? bus.cdb_value : bus.in_vj;
        nw.qj   = (hit && bus.in_qj == bus.cdb_tag) ? '0 : bus.in_qj;
        nw.vk   = (hit && bus.in_qk == bus.cdb_tag) ? bus.cdb_value : bus.in_vk;
        nw.qk   = (hit && bus.in_qk == bus.cdb_tag) ? '0 : bus.in_qk;
        loadable = !m_valid || bus.issue_ready;
        disp     = bus.in_valid && (fre >= 0);
        byp      = BYP && disp && loadable && (rdy < 0) && nw.qj == 0 && nw.qk == 0;
        if (hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && m_slot[i].qj == bus.cdb_tag) begin
                    m_slot[i].vj = bus.cdb_value;
                    m_slot[i].qj = '0;
                end
                if (m_busy[i] && m_slot[i].qk == bus.cdb_tag) begin
                    m_slot[i].vk = bus.cdb_value;
                    m_slot[i].qk = '0;
                end
            end
        end
        if (loadable) begin
            if (rdy >= 0) begin
                exp_q.push_back(pack_out(m_slot[rdy]));
                m_busy[rdy] = 1'b0;
                m_valid     = 1'b1;
            end else if (byp) begin
                exp_q.push_back(pack_out(nw));
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (disp && !byp) begin
            m_busy[fre] = 1'b1;
            m_slot[fre] = nw;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: per-cycle handshake state and in-order issue data.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", bus.in_ready, model_in_ready());
            chk("issue_valid", bus.issue_valid, m_valid);
            if (bus.issue_valid && bus.issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected: got dest %0d expected no issue", bus.issue_dest);
                end else begin
                    chk("issue_data", {bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest},
                        exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_disp(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                            input logic [TAG_W-1:0] dest);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_vj    = vj;
        bus.in_vk    = vk;
        bus.in_qj    = qj;
        bus.in_qk    = qk;
        bus.in_dest  = dest;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] value);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    // Counts cycles from the last tick until issue_valid shows, bounded.
    task automatic wait_issue(output int lat);
        lat = 1;
        while (!bus.issue_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        idle();
        bus.issue_ready = 1'b1;
        repeat (4) tick();
    endtask

    // Three waiting entries on tag 7 plus one instruction parked in the
    // output register behind a stalled ALU.
    task automatic fill_for_kill();
        bus.issue_ready = 1'b0;
        set_disp(OP_BGE, 32'h99, 32'h98, 0, 0, 9);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_disp(OP_SLL, 32'h50 + k, 32'h1, 7, 0, TAG_W'(5 + k));
            tick();
        end
        idle();
        tick();
        chk("kill_pre_valid", bus.issue_valid, 1'b1);
        chk("kill_pre_dest", bus.issue_dest, 9);
    endtask

    task automatic random_cycle();
        bus.in_valid    = ($urandom_range(0, 9) < 6);
        bus.in_op       = 3'($urandom_range(0, 3));
        bus.in_vj       = $urandom;
        bus.in_vk       = $urandom;
        bus.in_qj       = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 3));
        bus.in_qk       = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 3));
        bus.in_dest     = TAG_W'($urandom_range(0, 15));
        bus.cdb_valid   = ($urandom_range(0, 9) < 4);
        bus.cdb_tag     = TAG_W'($urandom_range(0, 3));
        bus.cdb_value   = $urandom;
        bus.issue_ready = ($urandom_range(0, 9) < 7);
        bus.flush       = ($urandom_range(0, 63) == 0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        idle();
        bus.issue_ready = 1'b0;
        bus.in_op = '0; bus.in_vj = '0; bus.in_vk = '0;
        bus.in_qj = '0; bus.in_qk = '0; bus.in_dest = '0;
        bus.cdb_value = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_issue_valid", bus.issue_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_issue_out", {bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest}, '0);

        // ADD 5+7 with both operands present
        bus.issue_ready = 1'b1;
        set_disp(OP_ADD, 5, 7, 0, 0, 3);
        tick();
        idle();
        wait_issue(lat);
        chk("add_latency", lat, BYP ? 1 : 2);
        chk("add_out", {bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest},
            {OP_ADD, 32'd5, 32'd9 - 32'd2, 4'd3});
        drain();

        // Operand j waits on tag 2, woken by the CDB
        set_disp(OP_MUL, 32'hDEAD, 9, 2, 0, 4);
        tick();
        idle();
        tick();
        set_cdb(2, 32'h100);
        tick();
        idle();
        wait_issue(lat);
        chk("wake_latency", lat, 2);
        chk("wake_src1", bus.issue_src1, 32'h100);
        chk("wake_src2", bus.issue_src2, 9);
        drain();

        // Same-cycle forward of operand k
        set_disp(OP_SLL, 32'h11, 32'h0, 0, 5, 8);
        set_cdb(5, 32'hABCD);
        tick();
        idle();
        wait_issue(lat);
        chk("fwd_latency", lat, BYP ? 1 : 2);
        chk("fwd_src2", bus.issue_src2, 32'hABCD);
        chk("fwd_src1", bus.issue_src1, 32'h11);
        drain();

        // Fill all entries waiting on tag 6, then release them together
        for (int k = 0; k < DEPTH; k++) begin
            set_disp(OP_ADD, 32'h200 + k, k, 6, 0, TAG_W'(10 + k));
            tick();
        end
        idle();
        chk("full_in_ready", bus.in_ready, 1'b0);
        set_cdb(6, 1);
        tick();
        idle();
        chk("full_wake_valid", bus.issue_valid, 1'b0);
        chk("full_wake_in_ready", bus.in_ready, 1'b0);
        tick();
        chk("full_first_in_ready", bus.in_ready, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            chk("full_seq_valid", bus.issue_valid, 1'b1);
            chk("full_seq_dest", bus.issue_dest, 10 + k);
            chk("full_seq_src1", bus.issue_src1, 1);
            tick();
        end
        chk("full_done_valid", bus.issue_valid, 1'b0);
        drain();

        // Stall: outputs stay frozen while the ALU holds off
        bus.issue_ready = 1'b0;
        set_disp(OP_MUL, 32'h11, 32'h22, 0, 0, 1);
        tick();
        set_disp(OP_BGE, 32'h33, 32'h44, 0, 0, 2);
        tick();
        idle();
        wait_issue(lat);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_out", {bus.issue_valid, bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest},
                {1'b1, OP_MUL, 32'h11, 32'h22, 4'd1});
        end
        bus.issue_ready = 1'b1;
        tick();
        chk("stall_next", {bus.issue_valid, bus.issue_op, bus.issue_src1, bus.issue_dest},
            {1'b1, OP_BGE, 32'h33, 4'd2});
        drain();

        // Flush with held entries and a pending output
        fill_for_kill();
        bus.flush = 1'b1;
        tick();
        idle();
        chk("flush_valid", bus.issue_valid, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        bus.issue_ready = 1'b1;
        set_cdb(7, 32'h777);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("flush_no_issue", bus.issue_valid, 1'b0);
            tick();
        end

        // Asynchronous reset in the middle of a cycle, same setup
        fill_for_kill();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_issue_out", {bus.issue_valid, bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest}, '0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        set_cdb(7, 32'h777);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("arst_no_issue", bus.issue_valid, 1'b0);
            tick();
        end

        // Randomized traffic against the model
        repeat (600) random_cycle();

        // Clear leftovers and confirm every prediction was consumed
        idle();
        bus.issue_ready = 1'b1;
        bus.flush = 1'b1;
        tick();
        idle();
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of station entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_W, default 4, width of rename/ROB tags; tag 0 means "value present".
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  dispatch request from decode.
REQ-006 in_ready  output  1  station can accept a dispatch this cycle.
REQ-007 in_op  input  3  ALU opcode, passed through unchanged (ADD/MUL/BGE/SLL encodings).
REQ-008 in_vj, in_vk  input  32 each  operand values (meaningful when matching tag is 0).
REQ-009 in_qj, in_qk  input  TAG_W each  producer tags of operands; 0 = value present.
REQ-010 in_dest  input  TAG_W  destination tag of the instruction.
REQ-011 cdb_valid  input  1; cdb_tag  input  TAG_W; cdb_value  input  32  result broadcast bus.
REQ-012 flush  input  1  discard all held instructions.
REQ-013 issue_valid  output  1; issue_ready  input  1  handshake toward the ALU.
REQ-014 issue_op  output  3; issue_src1, issue_src2  output  32; issue_dest  output  TAG_W  registered ALU operands.

Function
REQ-015 Dispatch SHALL occur when in_valid & in_ready; instruction written to lowest-index free entry.
REQ-016 in_ready SHALL be 1 iff at least one entry is free at cycle start; entries freed this cycle are not reusable until next cycle.
REQ-017 Wakeup: cdb_valid with cdb_tag != 0 SHALL, at the edge, copy cdb_value into every busy entry operand whose tag equals cdb_tag and clear that tag; cdb_tag 0 ignored.
REQ-018 Same-cycle forward: a dispatching operand whose in_q tag equals a valid nonzero cdb_tag SHALL be stored with cdb_value and tag 0.
REQ-019 An entry SHALL be ready when busy and both stored tags are 0.
REQ-020 Output register SHALL be loadable when issue_valid==0 or (issue_valid & issue_ready).
REQ-021 When loadable, the lowest-index ready entry SHALL move into the output register and be freed at the same edge; issue_valid set; otherwise issue_valid cleared if consumed.
REQ-022 issue_* outputs SHALL remain stable while issue_valid & !issue_ready.
REQ-023 Latency: dispatch with both operands present in cycle N (or last wakeup in cycle N) SHALL give earliest issue_valid in cycle N+2.
REQ-024 Throughput: one issue per cycle when issue_ready held high and ready entries exist.
REQ-025 Flush SHALL, at the edge, free all entries and clear issue_valid; dispatch and wakeup in the flush cycle are discarded; flush overrides all.
REQ-026 Simultaneous dispatch, wakeup, issue on same cycle SHALL all take effect; a freed slot and a dispatched slot never alias.

Reset
REQ-027 rst_n low SHALL immediately free all entries, clear issue_valid, zero issue_op/src1/src2/dest, independent of clk.
REQ-028 After reset release, in_ready SHALL be 1 and issue_valid 0 until first eligible dispatch.
REQ-029 Reset mid-operation SHALL drop held instructions without issuing them.

Configuration
REQ-030 Macro ALU_RS_BYPASS_EN, when defined, SHALL let a dispatch with both operands present (after REQ-018 forward) go directly into the output register when loadable and no stored entry is ready, giving issue_valid in cycle N+1 and consuming no entry.
REQ-031 Without ALU_RS_BYPASS_EN, all dispatches SHALL pass through an entry per REQ-023; all other behaviour identical.

Verification
REQ-032 Reset, then dispatch op=ADD vj=5 vk=7 qj=qk=0 dest=3 in cycle 1, issue_ready=1 -> issue_valid cycle 3 (cycle 2 with bypass), src1=5 src2=7 dest=3.
REQ-033 Dispatch qj=2 vk=9 dest=4; cycle 5 cdb_valid tag=2 value=0x100 -> issue_valid cycle 7, src1=0x100 src2=9.
REQ-034 Fill 4 entries all waiting on tag 6 -> in_ready=0 fifth cycle; cdb tag 6 value 1 -> four issues on consecutive cycles, indices 0..3 order, in_ready returns 1 the cycle after first issue.
REQ-035 Hold issue_ready=0 with issue_valid=1 for 3 cycles -> outputs unchanged; release -> next ready entry issues the following cycle.
REQ-036 Dispatch qk=5 in same cycle as cdb tag 5 value 0xABCD -> stored ready, issue_src2=0xABCD.
REQ-037 Three entries held plus pending output, assert flush (and separately rst_n low mid-cycle) -> issue_valid 0 next edge (immediately for reset), in_ready 1, no later issue of held instructions.
